// File: rtl/booth_wallace_mul_pkg.sv
// booth_wallace_mul_pkg: widths and Booth select codes shared by the multiplier
package booth_wallace_mul_pkg;
    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;
    localparam int PP_NUM = 16;
    localparam int X_W    = MUL_W + 2;

    typedef enum logic [2:0] {SEL_ZERO, SEL_POS1, SEL_POS2, SEL_NEG1, SEL_NEG2} sel_e;

    function automatic sel_e booth_code(input logic [2:0] g);
        return (g == 3'b000 || g == 3'b111) ? SEL_ZERO :
               (g == 3'b001 || g == 3'b010) ? SEL_POS1 :
               (g == 3'b011)                ? SEL_POS2 :
               (g == 3'b100)                ? SEL_NEG2 : SEL_NEG1;
    endfunction
endpackage

// File: rtl/booth_wallace_mul_csa.sv
// booth_wallace_mul_csa: one row of 3:2 carry-save adders, carry row pre-shifted and truncated
module booth_wallace_mul_csa #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] cy
);
    assign s  = a ^ b ^ c;
    assign cy = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
endmodule

// File: rtl/booth_wallace_mul.sv
// booth_wallace_mul: 32x32 signed radix-4 Booth / Wallace-tree multiplier with registered 64-bit product
module booth_wallace_mul
    import booth_wallace_mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [MUL_W-1:0]    src1,
    input  logic [MUL_W-1:0]    src2,
    output logic [PROD_W-1:0]   res
);
    logic [X_W-1:0]    x;
    logic [X_W-1:0]    x2;
    logic [MUL_W:0]    src2_ext;
    sel_e              sel [PP_NUM];
    logic [X_W-1:0]    mag [PP_NUM];
    logic [X_W-1:0]    val [PP_NUM];
    logic [PROD_W-1:0] neg_row;
    logic [PROD_W-1:0] l0 [17];
    logic [PROD_W-1:0] l1 [12];
    logic [PROD_W-1:0] l2 [8];
    logic [PROD_W-1:0] l3 [6];
    logic [PROD_W-1:0] l4 [4];
    logic [PROD_W-1:0] l5 [3];
    logic [PROD_W-1:0] l6 [2];
    logic [PROD_W-1:0] sum;

    assign x        = {{2{src1[MUL_W-1]}}, src1};
    assign x2       = {x[X_W-2:0], 1'b0};
    assign src2_ext = {src2, 1'b0};

    // Booth recode each multiplier triplet and build the partial-product rows plus the +1 negation row
    always_comb begin
        neg_row = '0;
        for (int i = 0; i < PP_NUM; i++) begin
            sel[i] = booth_code(src2_ext[2*i +: 3]);
            mag[i] = (sel[i] == SEL_POS2 || sel[i] == SEL_NEG2) ? x2 :
                     (sel[i] == SEL_ZERO) ? '0 : x;
            val[i] = (sel[i] == SEL_NEG1 || sel[i] == SEL_NEG2) ? ~mag[i] : mag[i];
            l0[i] = {{(PROD_W-X_W){val[i][X_W-1]}}, val[i]} << (2*i);
            neg_row[2*i] = (sel[i] == SEL_NEG1 || sel[i] == SEL_NEG2);
        end
        l0[PP_NUM] = neg_row;
    end

    for (genvar j = 0; j < 5; j++) begin : g_l1
        booth_wallace_mul_csa #(.W(PROD_W)) u_csa (.a(l0[3*j]), .b(l0[3*j+1]), .c(l0[3*j+2]), .s(l1[2*j]), .cy(l1[2*j+1]));
    end
    assign l1[10] = l0[15];
    assign l1[11] = l0[16];

    for (genvar j = 0; j < 4; j++) begin : g_l2
        booth_wallace_mul_csa #(.W(PROD_W)) u_csa (.a(l1[3*j]), .b(l1[3*j+1]), .c(l1[3*j+2]), .s(l2[2*j]), .cy(l2[2*j+1]));
    end

    for (genvar j = 0; j < 2; j++) begin : g_l3
        booth_wallace_mul_csa #(.W(PROD_W)) u_csa (.a(l2[3*j]), .b(l2[3*j+1]), .c(l2[3*j+2]), .s(l3[2*j]), .cy(l3[2*j+1]));
    end
    assign l3[4] = l2[6];
    assign l3[5] = l2[7];

    for (genvar j = 0; j < 2; j++) begin : g_l4
        booth_wallace_mul_csa #(.W(PROD_W)) u_csa (.a(l3[3*j]), .b(l3[3*j+1]), .c(l3[3*j+2]), .s(l4[2*j]), .cy(l4[2*j+1]));
    end

    booth_wallace_mul_csa #(.W(PROD_W)) u_csa5 (.a(l4[0]), .b(l4[1]), .c(l4[2]), .s(l5[0]), .cy(l5[1]));
    assign l5[2] = l4[3];

    booth_wallace_mul_csa #(.W(PROD_W)) u_csa6 (.a(l5[0]), .b(l5[1]), .c(l5[2]), .s(l6[0]), .cy(l6[1]));

    assign sum = l6[0] + l6[1];

    // Register the product; reset clears it and drops whatever was in flight
    always_ff @(posedge clk) begin
        res <= rst ? '0 : sum;
    end
endmodule

// File: tb/tb_booth_wallace_mul.sv
// tb_booth_wallace_mul: scoreboard bench for the registered Booth/Wallace multiplier
module tb_booth_wallace_mul;
    typedef struct {
        logic [63:0] exp;
        string       name;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [63:0] res;
    item_t       q[$];
    int          checks = 0;
    int          passed = 0;
    bit          done = 1'b0;

    booth_wallace_mul dut (.clk(clk), .rst(rst), .src1(src1), .src2(src2), .res(res));

    always #5 clk = ~clk;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e, input string nm);
        @(negedge clk);
        rst  = r;
        src1 = a;
        src2 = b;
        q.push_back('{exp: e, name: nm});
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                it = q.pop_front();
                checks++;
                if (res === it.exp) passed++;
                else $display("FAIL %s: res=%h expected=%h", it.name, res, it.exp);
            end
        end
    end

    initial begin : stim
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] corners [5];
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h80000000;
        corners[4] = 32'h7FFFFFFF;
        drive(1'b1, 32'hFFFFFFFF, 32'h7, 64'h0, "reset0");
        drive(1'b1, 32'hFFFFFFFF, 32'h7, 64'h0, "reset1");
        drive(1'b0, 32'h00000003, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFA, "3_x_m2");
        drive(1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000, "min_x_min");
        drive(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, "min_x_m1");
        drive(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, "max_x_max");
        drive(1'b0, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, "max_x_min");
        drive(1'b0, 32'h00000005, 32'h00000007, 64'h0000000000000023, "5_x_7");
        drive(1'b0, 32'hFFFFFFFB, 32'h00000007, 64'hFFFFFFFFFFFFFFDD, "m5_x_7");
        drive(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "m1_x_m1");
        drive(1'b0, 32'h00000001, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, "1_x_m1");
        drive(1'b0, 32'h00000000, 32'hDEADBEEF, 64'h0000000000000000, "0_x_any");
        drive(1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000, "2p16_sq");
        drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 64'h0, "mid_reset");
        drive(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE, 64'h0000000000000004, "after_reset");
        for (int k = 0; k < 10000; k++) begin
            a = (k % 7 == 0) ? corners[k % 5] : $urandom;
            b = (k % 11 == 0) ? corners[(k / 11) % 5] : $urandom;
            drive(1'b0, a, b, smul(a, b), "random");
        end
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
    end

    initial begin : finisher
        wait (done);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: pending=%0d expected=0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: run did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
